dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter sharing the single data memory between the core's load/store port (A) and a loader/debug port (B). It sits between the datapath's data-memory signals (address, write data, 4-bit byte write enable from the control unit) and a synchronous-read RAM. Requesters are granted one access at a time by an issue/data state machine. The core is frozen through `a_stall` until its access completes.

## Interface
- `ADDR_WIDTH`, default 10: word-address width of the RAM.
- `CNT_WIDTH`, default 16: width of the stall-cycle counter.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `a_req`, in, 1: core access request. Held high for the whole instruction.
- `a_wren`, in, 4: core byte write enables (0000 = read, 1111 = sw, 0011 = sh, 0001 = sb).
- `a_addr`, in, ADDR_WIDTH: core word address.
- `a_wdata`, in, 32: core write data.
- `a_rdata`, out, 32: core read data. Valid in the A data cycle.
- `a_stall`, out, 1: freezes the core's PC and register-file write.
- `b_valid`, in, 1: B request. Must stay stable until `b_ready`.
- `b_ready`, out, 1: B request accepted this cycle.
- `b_wren`, in, 4: B byte write enables (0000 = read).
- `b_addr`, in, ADDR_WIDTH: B word address.
- `b_wdata`, in, 32: B write data.
- `b_rvalid`, out, 1: one-cycle pulse; `b_rdata` valid (reads only).
- `b_rdata`, out, 32: B read data.
- `mem_en`, out, 1: RAM access strobe.
- `mem_wren`, out, 4: RAM byte write enables.
- `mem_addr`, out, ADDR_WIDTH: RAM word address.
- `mem_wdata`, out, 32: RAM write data.
- `mem_rdata`, in, 32: RAM read data, registered, 1-cycle latency.
- `stall_cycles`, out, CNT_WIDTH: saturating count of cycles with `a_stall`=1.

## Operation
- **States:** IDLE, A_DATA, B_DATA. `last_grant` register (A/B) resets to B, so A wins the first tie.
- **Granting in IDLE:**
  - Only `a_req` high: grant A.
  - Only `b_valid` high: grant B.
  - Both high: grant the port that is not `last_grant`.
  - Neither high: stay in IDLE.
- **Issue cycle (IDLE with a grant):**
  - `mem_en`=1; `mem_wren`, `mem_addr` and `mem_wdata` come combinationally from the granted port.
  - Next state is A_DATA or B_DATA; `last_grant` updates.
- **B issue cycle:** `b_ready`=1.
- **A_DATA:**
  - `a_rdata`=`mem_rdata` and `a_stall`=0, so the core completes.
  - Next state is IDLE unconditionally. A is never re-granted in its own data cycle.
- **B_DATA:**
  - `b_rvalid`=1 if the accepted `b_wren` was 0000 (registered), with `b_rdata`=`mem_rdata`.
  - Next state is IDLE.
- **Core stall:** `a_stall` = `a_req` AND NOT (state==A_DATA). It is forced to 0 while `rst` is high.
- **Outside an issue cycle:** `mem_en`=0, `mem_wren`=0000, `mem_addr`=0, `mem_wdata`=0.
- **Byte enables:** passed through unmodified. Byte-lane placement of write data is the requester's responsibility.
- **Throughput:** one access every 2 cycles. Under continuous contention, A and B alternate.
- **Stall counter:** `stall_cycles` increments each cycle `a_stall`=1 and saturates at all-ones.
- **Reset:**
  - `rst` high at any state (including A_DATA/B_DATA) sets state to IDLE, `last_grant` to B and `stall_cycles` to 0.
  - A pending `b_rvalid` is dropped. A write already presented to the RAM in its issue cycle is not undone.
- **Reset values of outputs:**
  - `a_stall`=0, `b_ready`=0, `b_rvalid`=0.
  - `mem_en`=0, `mem_wren`=0, `mem_addr`=0, `mem_wdata`=0.
  - `stall_cycles`=0.
  - `a_rdata` and `b_rdata` mirror `mem_rdata` and carry no meaning outside their data cycle.

## Timing
- A access (read or write) takes 2 cycles:
  - Cycle 0: issue, `a_stall`=1.
  - Cycle 1: A_DATA, `a_stall`=0, read data valid.
- If B is granted when `a_req` rises, A's stall lasts 3 cycles (B issue, B_DATA, A issue) before A_DATA.
- B read: `b_ready` in cycle N, `b_rvalid` in cycle N+1.
- B write: `b_ready` in cycle N, RAM written at the end of cycle N, no `b_rvalid`.
- Earliest next grant after any access: 2 cycles after its issue.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined: A always wins ties and `last_grant` is not used. B is served only when `a_req` is low in IDLE; B can starve.
- Not defined: round-robin as described in Operation.

## Test plan
- Core lw alone, RAM[0x10]=0x12345678, `a_req`=1, `a_wren`=0000, `a_addr`=0x10 -> cycle 0: `mem_en`=1, `mem_addr`=0x10, `a_stall`=1; cycle 1: `a_stall`=0, `a_rdata`=0x12345678; `stall_cycles`=1.
- Core sw 0xDEADBEEF to 0x20, then B read 0x20 -> `mem_wren`=1111 for exactly one cycle; `b_rvalid`=1 with `b_rdata`=0xDEADBEEF one cycle after `b_ready`.
- `a_req` and `b_valid` both high continuously from reset -> grants A,B,A,B; `b_ready` in cycles 2, 6, …; `a_stall` low in cycles 1, 5, ….
- B sb with `b_wren`=0001 and data 0x000000AA to a word holding 0x11223344 -> read-back 0x112233AA; `b_rvalid` stays 0 for the write.
- `rst` asserted during B_DATA of a read -> next cycle: state IDLE, `b_rvalid`=0, `stall_cycles`=0; the next tie is granted to A.
- `DMEM_ARB_FIXED_PRIO_EN` build, `a_req` held high 20 cycles with `b_valid` high -> `b_ready` never asserts; it asserts in the first IDLE cycle after `a_req` drops.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one synchronous-read data RAM between the core load/store port (A)
//   and a loader/debug port (B). Each access is an issue cycle followed by a
//   data cycle, so the RAM sees at most one access every two cycles. Ties are
//   broken round-robin. Define DMEM_ARB_FIXED_PRIO_EN to make A always win
//   ties instead; B is then served only when a_req is low and can starve.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   a_req/a_wren/a_addr/a_wdata  core request (held for the whole instruction)
//   a_rdata, a_stall    core read data (valid in A data cycle), core freeze
//   b_valid/b_wren/b_addr/b_wdata, b_ready   B valid/ready request
//   b_rvalid, b_rdata   B read-data pulse, one cycle after b_ready (reads only)
//   mem_*               RAM strobe, byte enables, address, write/read data
//   stall_cycles        saturating count of cycles with a_stall high
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic [3:0]            a_wren,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [31:0]           a_wdata,
  output logic [31:0]           a_rdata,
  output logic                  a_stall,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [3:0]            b_wren,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [31:0]           b_wdata,
  output logic                  b_rvalid,
  output logic [31:0]           b_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_wren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  typedef enum logic [1:0] {IDLE = 2'd0, A_DATA = 2'd1, B_DATA = 2'd2} state_e;

  state_e               state_q, state_d;
  logic                 b_rd_q, b_rd_d;     // accepted B access was a read
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic                 grant_a, grant_b;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic                 last_b_q, last_b_d; // 1: B won the last grant
`endif

  // Arbitration: only IDLE issues. Gated by rst so nothing reaches the RAM
  // while reset is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && state_q == IDLE) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      grant_a = a_req;
`else
      grant_a = a_req && (!b_valid || last_b_q);
`endif
      grant_b = b_valid && !grant_a;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      b_rd_q   <= 1'b0;
      stall_q  <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_b_q <= 1'b1;   // A wins the first tie
`endif
    end else begin
      state_q  <= state_d;
      b_rd_q   <= b_rd_d;
      stall_q  <= stall_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_b_q <= last_b_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    b_rd_d   = b_rd_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_b_d = last_b_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_a) begin
          state_d = A_DATA;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_b_d = 1'b0;
`endif
        end else if (grant_b) begin
          state_d = B_DATA;
          b_rd_d  = (b_wren == 4'b0000);
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_b_d = 1'b1;
`endif
        end
      end
      // Data cycles always return to IDLE: A is never re-granted back to back.
      A_DATA:  state_d = IDLE;
      B_DATA:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    stall_d = (a_stall && !(&stall_q)) ? stall_q + CNT_WIDTH'(1) : stall_q;
  end

  // Outputs
  always_comb begin
    mem_en    = grant_a | grant_b;
    mem_wren  = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_a) begin
      mem_wren  = a_wren;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (grant_b) begin
      mem_wren  = b_wren;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
    b_ready      = grant_b;
    a_stall      = !rst && a_req && (state_q != A_DATA);
    b_rvalid     = !rst && (state_q == B_DATA) && b_rd_q;
    a_rdata      = mem_rdata;
    b_rdata      = mem_rdata;
    stall_cycles = stall_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int AW  = 10;
  localparam int CW  = 6;
  localparam int SAT = 63;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, b_valid = 1'b0;
  logic [3:0]    a_wren = '0, b_wren = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [31:0]   a_wdata = '0, b_wdata = '0;
  logic [31:0]   a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic          a_stall, b_ready, b_rvalid, mem_en;
  logic [3:0]    mem_wren;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] ram     [0:1023];  // environment RAM driven by the DUT
  logic [31:0] ref_mem [0:1023];  // what memory must hold, from requester intent

  // Reference model: who owns the data cycle now (0 none, 1 A, 2 B)
  int          m_owner  = 0;
  bit          m_last_b = 1'b1;
  bit          m_a_rd = 1'b0, m_b_rd = 1'b0;
  bit          m_a_done = 1'b0, m_b_acc = 1'b0;
  logic [31:0] m_exp = '0;
  int          m_stall = 0;

  logic [3:0] wtab [0:7];

  dmem_arbiter #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wren(a_wren), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_stall(a_stall),
    .b_valid(b_valid), .b_ready(b_ready), .b_wren(b_wren), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Which requester the arbiter must pick when the RAM is free
  function automatic int pick();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (a_req) return 1;
    if (b_valid) return 2;
    return 0;
`else
    if (a_req && b_valid) return m_last_b ? 1 : 2;
    if (a_req) return 1;
    if (b_valid) return 2;
    return 0;
`endif
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Environment RAM: synchronous read, byte writes
  always @(posedge clk) begin
    if (mem_en) begin
      ram[mem_addr] <= merge(ram[mem_addr], mem_wdata, mem_wren);
      mem_rdata     <= ram[mem_addr];
    end
  end

  // Model update
  always @(posedge clk) begin
    if (rst) begin
      m_owner  <= 0;
      m_last_b <= 1'b1;
      m_stall  <= 0;
      m_a_done <= 1'b0;
      m_b_acc  <= 1'b0;
    end else begin
      if (a_req && m_owner != 1) m_stall <= (m_stall >= SAT) ? SAT : m_stall + 1;
      m_a_done <= (m_owner == 1);
      m_b_acc  <= (m_owner == 0 && pick() == 2);
      if (m_owner != 0) m_owner <= 0;
      else if (pick() == 1) begin
        m_owner  <= 1;
        m_last_b <= 1'b0;
        m_a_rd   <= (a_wren == 4'b0000);
        m_exp    <= ref_mem[a_addr];
        ref_mem[a_addr] <= merge(ref_mem[a_addr], a_wdata, a_wren);
      end else if (pick() == 2) begin
        m_owner  <= 2;
        m_last_b <= 1'b1;
        m_b_rd   <= (b_wren == 4'b0000);
        m_exp    <= ref_mem[b_addr];
        ref_mem[b_addr] <= merge(ref_mem[b_addr], b_wdata, b_wren);
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    int w;
    if (chk_en) begin
      if (rst) begin
        cmp("rst_a_stall", 32'(a_stall), 32'd0);
        cmp("rst_b_ready", 32'(b_ready), 32'd0);
        cmp("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        cmp("rst_mem_en", 32'(mem_en), 32'd0);
        cmp("rst_mem_wren", 32'(mem_wren), 32'd0);
        cmp("rst_mem_addr", 32'(mem_addr), 32'd0);
        cmp("rst_mem_wdata", mem_wdata, 32'd0);
      end else begin
        w = (m_owner == 0) ? pick() : 0;
        cmp("mem_en", 32'(mem_en), 32'(w != 0));
        cmp("mem_wren", 32'(mem_wren), w == 1 ? 32'(a_wren) : w == 2 ? 32'(b_wren) : 32'd0);
        cmp("mem_addr", 32'(mem_addr), w == 1 ? 32'(a_addr) : w == 2 ? 32'(b_addr) : 32'd0);
        cmp("mem_wdata", mem_wdata, w == 1 ? a_wdata : w == 2 ? b_wdata : 32'd0);
        cmp("b_ready", 32'(b_ready), 32'(w == 2));
        cmp("a_stall", 32'(a_stall), 32'(a_req && m_owner != 1));
        cmp("b_rvalid", 32'(b_rvalid), 32'(m_owner == 2 && m_b_rd));
        if (m_owner == 1 && m_a_rd) cmp("a_rdata", a_rdata, m_exp);
        if (m_owner == 2 && m_b_rd) cmp("b_rdata", b_rdata, m_exp);
      end
      cmp("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0; a_wren = '0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_wren = '0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic rand_phase(input int n);
    for (int c = 0; c < n; c++) begin
      if (!a_req || m_a_done) begin
        a_req   = ($urandom_range(0, 2) != 0);
        a_wren  = wtab[$urandom_range(0, 7)];
        a_addr  = AW'($urandom_range(0, 15));
        a_wdata = $urandom();
      end
      if (!b_valid || m_b_acc) begin
        b_valid = ($urandom_range(0, 2) == 0);
        b_wren  = wtab[$urandom_range(0, 7)];
        b_addr  = AW'($urandom_range(0, 15));
        b_wdata = $urandom();
      end
      rst = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] br, st;
    bit seen;
    wtab[0] = 4'b0000; wtab[1] = 4'b0000; wtab[2] = 4'b1111; wtab[3] = 4'b0011;
    wtab[4] = 4'b0001; wtab[5] = 4'b1100; wtab[6] = 4'b0010; wtab[7] = 4'b1000;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 32'(i) * 32'h9E3779B9;
      ref_mem[i] = 32'(i) * 32'h9E3779B9;
    end
    ram[16] = 32'h12345678; ref_mem[16] = 32'h12345678;
    ram[48] = 32'h11223344; ref_mem[48] = 32'h11223344;
    chk_en = 1'b1;

    // Core lw alone
    do_reset();
    a_req = 1'b1; a_wren = 4'b0000; a_addr = 10'h10;
    @(negedge clk);
    cmp("lw_mem_en", 32'(mem_en), 32'd1);
    cmp("lw_mem_addr", 32'(mem_addr), 32'h10);
    cmp("lw_stall0", 32'(a_stall), 32'd1);
    cyc();
    @(negedge clk);
    cmp("lw_stall1", 32'(a_stall), 32'd0);
    cmp("lw_rdata", a_rdata, 32'h12345678);
    cmp("lw_cnt", 32'(stall_cycles), 32'd1);
    cyc();
    a_req = 1'b0;

    // Core sw then B read of the same word
    a_req = 1'b1; a_wren = 4'b1111; a_addr = 10'h20; a_wdata = 32'hDEADBEEF;
    @(negedge clk);
    cmp("sw_wren_issue", 32'(mem_wren), 32'hF);
    cyc();
    @(negedge clk);
    cmp("sw_wren_data", 32'(mem_wren), 32'h0);
    cyc();
    a_req = 1'b0; a_wren = '0;
    b_valid = 1'b1; b_wren = 4'b0000; b_addr = 10'h20;
    @(negedge clk);
    cmp("brd_ready", 32'(b_ready), 32'd1);
    cyc();
    b_valid = 1'b0;
    @(negedge clk);
    cmp("brd_rvalid", 32'(b_rvalid), 32'd1);
    cmp("brd_rdata", b_rdata, 32'hDEADBEEF);
    cyc();

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // A held high: B starves, then is served in the first IDLE after a_req drops
    do_reset();
    a_req = 1'b1; a_addr = 10'h3; b_valid = 1'b1; b_addr = 10'h4;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_ready) seen = 1'b1;
      cyc();
    end
    cmp("fp_starve", 32'(seen), 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    cmp("fp_grant", 32'(b_ready), 32'd1);
    cyc();
    b_valid = 1'b0;
    cyc();
`else
    // Continuous contention from reset: A,B,A,B
    rst = 1'b1; idle();
    a_req = 1'b1; a_addr = 10'h5; b_valid = 1'b1; b_addr = 10'h6;
    cyc(); cyc();
    rst = 1'b0;
    br = '0; st = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i < 8) begin
        br[i] = b_ready;
        st[i] = a_stall;
      end
      cyc();
    end
    cmp("rr_b_ready", 32'(br), 32'h44);
    cmp("rr_a_stall", 32'(st), 32'hDD);
    cmp("cnt_saturate", 32'(stall_cycles), 32'(SAT));
    a_req = 1'b0; b_valid = 1'b0;
`endif

    // Reset during B_DATA of a read
    b_valid = 1'b1; b_wren = 4'b0000; b_addr = 10'h30;
    cyc();
    b_valid = 1'b0;
    rst = 1'b1;
    a_req = 1'b1; a_wren = 4'b0000; a_addr = 10'h5;
    @(negedge clk);
    cmp("rstb_rvalid", 32'(b_rvalid), 32'd0);
    cmp("rstb_stall", 32'(a_stall), 32'd0);
    cyc();
    rst = 1'b0;
    b_valid = 1'b1; b_wren = 4'b0000; b_addr = 10'h6;
    @(negedge clk);
    cmp("rstb_cnt", 32'(stall_cycles), 32'd0);
    cmp("rstb_rvalid2", 32'(b_rvalid), 32'd0);
    cmp("rstb_tie_b", 32'(b_ready), 32'd0);
    cmp("rstb_tie_addr", 32'(mem_addr), 32'h5);
    cyc();
    cyc();
    a_req = 1'b0;
    cyc();
    b_valid = 1'b0;
    cyc();

    // B sb then read-back
    do_reset();
    b_valid = 1'b1; b_wren = 4'b0001; b_addr = 10'h30; b_wdata = 32'h000000AA;
    @(negedge clk);
    cmp("sb_ready", 32'(b_ready), 32'd1);
    cyc();
    b_valid = 1'b0;
    @(negedge clk);
    cmp("sb_no_rvalid", 32'(b_rvalid), 32'd0);
    cyc();
    b_valid = 1'b1; b_wren = 4'b0000;
    @(negedge clk);
    cmp("sbrd_ready", 32'(b_ready), 32'd1);
    cyc();
    b_valid = 1'b0;
    @(negedge clk);
    cmp("sbrd_rvalid", 32'(b_rvalid), 32'd1);
    cmp("sbrd_rdata", b_rdata, 32'h112233AA);
    cyc();

    // Randomized traffic against the model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      rand_phase(2000);
    end
    idle();
    cyc();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
